// File: rtl/panda_dmem_arbiter.sv
// Two-port data-memory arbiter: core has fixed priority, ext is protected by a
// burst limiter. One outstanding req/gnt/rvalid transaction toward memory.
module panda_dmem_arbiter #(
    parameter int unsigned MaxCoreBurst = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        core_req_i,
    input  logic [31:0] core_addr_i,
    input  logic [3:0]  core_we_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    output logic [31:0] core_rdata_o,

    input  logic        ext_req_i,
    input  logic [31:0] ext_addr_i,
    input  logic [3:0]  ext_we_i,
    input  logic [31:0] ext_wdata_i,
    output logic        ext_gnt_o,
    output logic        ext_rvalid_o,
    output logic [31:0] ext_rdata_o,

    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned CntW = 4;
    localparam logic [CntW-1:0] BurstMax = CntW'(MaxCoreBurst);

    typedef enum logic {
        IDLE,
        WAIT_RESP
    } state_e;

    state_e          r_state;
    logic            r_owner;   // 0 = core, 1 = ext
    logic [CntW-1:0] r_cnt;

    logic w_idle;
    logic w_burst_full;
    logic w_ext_sel;
    logic w_core_sel;
    logic w_grant;
    logic w_resp;

    assign w_idle       = (r_state == IDLE);
    assign w_burst_full = (r_cnt == BurstMax);
    // Ext only preempts the core once the core has used up its burst allowance.
    assign w_ext_sel    = ext_req_i & (~core_req_i | w_burst_full);
    assign w_core_sel   = core_req_i & ~w_ext_sel;
    assign w_grant      = w_idle & mem_gnt_i & (w_core_sel | w_ext_sel);
    assign w_resp       = (r_state == WAIT_RESP) & mem_rvalid_i;

    assign mem_req_o  = w_idle & (core_req_i | ext_req_i);
    assign core_gnt_o = w_idle & mem_gnt_i & w_core_sel;
    assign ext_gnt_o  = w_idle & mem_gnt_i & w_ext_sel;

    // Request payload mux toward memory; zero whenever nothing is requested.
    always_comb begin
        mem_addr_o  = 32'h0;
        mem_we_o    = 4'h0;
        mem_wdata_o = 32'h0;
        if (w_idle && w_ext_sel) begin
            mem_addr_o  = ext_addr_i;
            mem_we_o    = ext_we_i;
            mem_wdata_o = ext_wdata_i;
        end else if (w_idle && w_core_sel) begin
            mem_addr_o  = core_addr_i;
            mem_we_o    = core_we_i;
            mem_wdata_o = core_wdata_i;
        end
    end

    // Zero-latency response steering to the transaction owner.
    always_comb begin
        core_rvalid_o = 1'b0;
        core_rdata_o  = 32'h0;
        ext_rvalid_o  = 1'b0;
        ext_rdata_o   = 32'h0;
        if (w_resp) begin
            if (r_owner) begin
                ext_rvalid_o = 1'b1;
                ext_rdata_o  = mem_rdata_i;
            end else begin
                core_rvalid_o = 1'b1;
                core_rdata_o  = mem_rdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state <= WAIT_RESP;
                        r_owner <= w_ext_sel;
                        if (w_ext_sel || !ext_req_i) begin
                            r_cnt <= '0;
                        end else if (!w_burst_full) begin
                            r_cnt <= r_cnt + CntW'(1);
                        end
                    end
                end
                WAIT_RESP: begin
                    if (mem_rvalid_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_panda_dmem_arbiter.sv
// Directed testbench for panda_dmem_arbiter: inputs change 2 time units after the
// rising edge and combinational outputs are sampled 1 unit later.
module tb_panda_dmem_arbiter;

    logic        clk_i;
    logic        rst_ni;
    logic        core_req_i;
    logic [31:0] core_addr_i;
    logic [3:0]  core_we_i;
    logic [31:0] core_wdata_i;
    logic        core_gnt_o;
    logic        core_rvalid_o;
    logic [31:0] core_rdata_o;
    logic        ext_req_i;
    logic [31:0] ext_addr_i;
    logic [3:0]  ext_we_i;
    logic [31:0] ext_wdata_i;
    logic        ext_gnt_o;
    logic        ext_rvalid_o;
    logic [31:0] ext_rdata_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int checks;
    int errors;

    panda_dmem_arbiter #(.MaxCoreBurst(4)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .core_req_i   (core_req_i),
        .core_addr_i  (core_addr_i),
        .core_we_i    (core_we_i),
        .core_wdata_i (core_wdata_i),
        .core_gnt_o   (core_gnt_o),
        .core_rvalid_o(core_rvalid_o),
        .core_rdata_o (core_rdata_o),
        .ext_req_i    (ext_req_i),
        .ext_addr_i   (ext_addr_i),
        .ext_we_i     (ext_we_i),
        .ext_wdata_i  (ext_wdata_i),
        .ext_gnt_o    (ext_gnt_o),
        .ext_rvalid_o (ext_rvalid_o),
        .ext_rdata_o  (ext_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic clear_inputs();
        core_req_i   = 1'b0;
        core_addr_i  = 32'h0;
        core_we_i    = 4'h0;
        core_wdata_i = 32'h0;
        ext_req_i    = 1'b0;
        ext_addr_i   = 32'h0;
        ext_we_i     = 4'h0;
        ext_wdata_i  = 32'h0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        clear_inputs();
        #3;
        checks++;
        if ({core_gnt_o, core_rvalid_o, ext_gnt_o, ext_rvalid_o, mem_req_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {core_gnt_o, core_rvalid_o, ext_gnt_o, ext_rvalid_o, mem_req_o});
        end
        checks++;
        if ({core_rdata_o, ext_rdata_o} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 0", {core_rdata_o, ext_rdata_o});
        end
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_core_load();
        core_req_i  = 1'b1;
        core_addr_i = 32'h100;
        core_we_i   = 4'h0;
        mem_gnt_i   = 1'b1;
        #1;
        checks++;
        if ({mem_req_o, core_gnt_o, ext_gnt_o} !== 3'b110) begin
            errors++;
            $display("FAIL core_load_gnt: got %b expected 110", {mem_req_o, core_gnt_o, ext_gnt_o});
        end
        checks++;
        if ({mem_addr_o, mem_we_o} !== {32'h100, 4'h0}) begin
            errors++;
            $display("FAIL core_load_addr: got %h/%h expected 100/0", mem_addr_o, mem_we_o);
        end
        tick();
        core_req_i   = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEADBEEF;
        #1;
        checks++;
        if ({core_rvalid_o, core_rdata_o, core_gnt_o, mem_req_o} !== {1'b1, 32'hDEADBEEF, 2'b00}) begin
            errors++;
            $display("FAIL core_load_resp: got rvalid %b rdata %h gnt %b req %b expected 1 deadbeef 0 0",
                     core_rvalid_o, core_rdata_o, core_gnt_o, mem_req_o);
        end
        checks++;
        if ({ext_gnt_o, ext_rvalid_o, ext_rdata_o} !== 34'h0) begin
            errors++;
            $display("FAIL core_load_ext_quiet: got %b %b %h expected 0 0 0",
                     ext_gnt_o, ext_rvalid_o, ext_rdata_o);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (core_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL core_load_rvalid_pulse: got %b expected 0", core_rvalid_o);
        end
    endtask

    task automatic test_ext_store();
        tick();
        ext_req_i   = 1'b1;
        ext_addr_i  = 32'h200;
        ext_we_i    = 4'b0011;
        ext_wdata_i = 32'h1234;
        mem_gnt_i   = 1'b1;
        #1;
        checks++;
        if ({mem_addr_o, mem_we_o, mem_wdata_o} !== {32'h200, 4'b0011, 32'h1234}) begin
            errors++;
            $display("FAIL ext_store_payload: got %h/%b/%h expected 200/0011/1234",
                     mem_addr_o, mem_we_o, mem_wdata_o);
        end
        checks++;
        if ({ext_gnt_o, core_gnt_o} !== 2'b10) begin
            errors++;
            $display("FAIL ext_store_gnt: got %b expected 10", {ext_gnt_o, core_gnt_o});
        end
        tick();
        ext_req_i    = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hA5A50000;
        #1;
        checks++;
        if ({ext_rvalid_o, ext_rdata_o, core_rvalid_o, core_rdata_o} !== {1'b1, 32'hA5A50000, 33'h0}) begin
            errors++;
            $display("FAIL ext_store_resp: got %b %h core %b %h expected 1 a5a50000 core 0 0",
                     ext_rvalid_o, ext_rdata_o, core_rvalid_o, core_rdata_o);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_starvation();
        logic [9:0] exp_ext;
        exp_ext = 10'b1000010000;
        core_req_i  = 1'b1;
        core_addr_i = 32'h400;
        ext_req_i   = 1'b1;
        ext_addr_i  = 32'h800;
        for (int i = 0; i < 10; i++) begin
            mem_gnt_i    = 1'b1;
            mem_rvalid_i = 1'b0;
            #1;
            checks++;
            if ({core_gnt_o, ext_gnt_o} !== {~exp_ext[i], exp_ext[i]}) begin
                errors++;
                $display("FAIL starve_gnt[%0d]: got core %b ext %b expected core %b ext %b",
                         i, core_gnt_o, ext_gnt_o, ~exp_ext[i], exp_ext[i]);
            end
            checks++;
            if (mem_addr_o !== (exp_ext[i] ? 32'h800 : 32'h400)) begin
                errors++;
                $display("FAIL starve_addr[%0d]: got %h expected %h",
                         i, mem_addr_o, exp_ext[i] ? 32'h800 : 32'h400);
            end
            tick();
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'(i);
            #1;
            checks++;
            if ({core_rvalid_o, ext_rvalid_o} !== {~exp_ext[i], exp_ext[i]}) begin
                errors++;
                $display("FAIL starve_rvalid[%0d]: got core %b ext %b expected core %b ext %b",
                         i, core_rvalid_o, ext_rvalid_o, ~exp_ext[i], exp_ext[i]);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_mem_stall();
        core_req_i  = 1'b1;
        core_addr_i = 32'h300;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({mem_req_o, core_gnt_o} !== 2'b10) begin
                errors++;
                $display("FAIL stall_gnt_wait[%0d]: got req %b gnt %b expected 1 0",
                         i, mem_req_o, core_gnt_o);
            end
            tick();
        end
        mem_gnt_i = 1'b1;
        #1;
        checks++;
        if (core_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_gnt: got %b expected 1", core_gnt_o);
        end
        tick();
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({mem_req_o, core_gnt_o, core_rvalid_o} !== 3'b000) begin
                errors++;
                $display("FAIL stall_resp_wait[%0d]: got req %b gnt %b rvalid %b expected 0 0 0",
                         i, mem_req_o, core_gnt_o, core_rvalid_o);
            end
            tick();
        end
        core_req_i   = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFEF00D;
        #1;
        checks++;
        if ({core_rvalid_o, core_rdata_o} !== {1'b1, 32'hCAFEF00D}) begin
            errors++;
            $display("FAIL stall_resp: got %b %h expected 1 cafef00d", core_rvalid_o, core_rdata_o);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        // Three core grants against a waiting ext, then a fourth left in flight.
        core_req_i = 1'b1;
        ext_req_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_gnt_i    = 1'b1;
            mem_rvalid_i = 1'b0;
            tick();
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b1;
            tick();
        end
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b0;
        #1;
        checks++;
        if ({core_gnt_o, ext_gnt_o} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_pre_gnt: got %b expected 10", {core_gnt_o, ext_gnt_o});
        end
        tick();
        clear_inputs();
        #1;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({core_gnt_o, ext_gnt_o, core_rvalid_o, ext_rvalid_o, mem_req_o} !== 5'b0) begin
            errors++;
            $display("FAIL rstmid_in_reset: got %b expected 00000",
                     {core_gnt_o, ext_gnt_o, core_rvalid_o, ext_rvalid_o, mem_req_o});
        end
        tick();
        rst_ni = 1'b1;
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h55AA55AA;
        #1;
        checks++;
        if ({core_rvalid_o, ext_rvalid_o, core_rdata_o, ext_rdata_o} !== 66'h0) begin
            errors++;
            $display("FAIL rstmid_stray_rvalid: got %b %b %h %h expected 0 0 0 0",
                     core_rvalid_o, ext_rvalid_o, core_rdata_o, ext_rdata_o);
        end
        tick();
        // Burst counter must be back at 0, so the core still beats a waiting ext.
        mem_rvalid_i = 1'b0;
        core_req_i   = 1'b1;
        core_addr_i  = 32'h500;
        ext_req_i    = 1'b1;
        ext_addr_i   = 32'h600;
        mem_gnt_i    = 1'b1;
        #1;
        checks++;
        if ({core_gnt_o, ext_gnt_o, mem_addr_o} !== {2'b10, 32'h500}) begin
            errors++;
            $display("FAIL rstmid_after_gnt: got %b %h expected 10 500",
                     {core_gnt_o, ext_gnt_o}, mem_addr_o);
        end
        tick();
        core_req_i   = 1'b0;
        ext_req_i    = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h00C0FFEE;
        #1;
        checks++;
        if ({core_rvalid_o, core_rdata_o, ext_rvalid_o} !== {1'b1, 32'h00C0FFEE, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_after_resp: got %b %h ext %b expected 1 00c0ffee ext 0",
                     core_rvalid_o, core_rdata_o, ext_rvalid_o);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_spurious_rvalid();
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hFFFFFFFF;
        #1;
        checks++;
        if ({core_rvalid_o, ext_rvalid_o, mem_req_o} !== 3'b000) begin
            errors++;
            $display("FAIL spurious_rvalid: got %b expected 000",
                     {core_rvalid_o, ext_rvalid_o, mem_req_o});
        end
        checks++;
        if ({core_rdata_o, ext_rdata_o} !== 64'h0) begin
            errors++;
            $display("FAIL spurious_rdata: got %h expected 0", {core_rdata_o, ext_rdata_o});
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_core_load();
        test_ext_store();
        test_starvation();
        test_mem_stall();
        test_reset_mid();
        test_spurious_rvalid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/panda_dmem_arbiter.md
Name: panda_dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the core load/store path (port "core") and an external master such as a debug or program loader (port "ext").
- Implements a req/gnt/rvalid handshake toward the memory with one outstanding transaction.
- Uses fixed core priority plus a starvation limiter so ext is guaranteed service.
- Sits between the memory stage and the data RAM/bus.

Parameters:
- MaxCoreBurst, 4, number of consecutive core grants allowed while ext is requesting before ext is forced to win (legal range 1..15).

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- core_req_i  input  1  core requests a transfer
- core_addr_i  input  32  core byte address
- core_we_i  input  4  core byte write enables; 0 means load
- core_wdata_i  input  32  core store data
- core_gnt_o  output  1  core request accepted this cycle
- core_rvalid_o  output  1  core response valid
- core_rdata_o  output  32  core load data
- ext_req_i, ext_addr_i, ext_we_i, ext_wdata_i  input  1/32/4/32  same meaning for ext
- ext_gnt_o, ext_rvalid_o, ext_rdata_o  output  1/1/32  same meaning for ext
- mem_req_o  output  1  request to memory
- mem_addr_o  output  32  address to memory
- mem_we_o  output  4  byte write enables to memory
- mem_wdata_o  output  32  write data to memory
- mem_gnt_i  input  1  memory accepted the request
- mem_rvalid_i  input  1  memory response valid (loads and stores both respond)
- mem_rdata_i  input  32  memory read data

Behaviour:
- State
  - FSM {IDLE, WAIT_RESP}.
  - Registered owner bit (0=core, 1=ext).
  - 4-bit burst counter.
- Reset (async, any state): state=IDLE, owner=core, counter=0. An in-flight transaction is abandoned; a late mem_rvalid_i after reset is ignored (state is IDLE).
- Arbitration in IDLE (combinational select):
  - ext wins if ext_req_i and (not core_req_i, or counter == MaxCoreBurst).
  - Otherwise core wins if core_req_i.
- mem_req_o = (state==IDLE) & (core_req_i | ext_req_i).
- mem_addr_o/mem_we_o/mem_wdata_o are muxed from the selected requester; they are 0 when no request.
- x_gnt_o = (state==IDLE) & mem_gnt_i & (x selected). Exactly one gnt at most. No gnt outside IDLE.
- On a grant, on that clock edge:
  - owner <= winner; state <= WAIT_RESP.
  - Counter update:
    - core granted while ext_req_i high: counter+1, saturating at MaxCoreBurst.
    - ext granted: counter <= 0.
    - core granted with ext_req_i low: counter <= 0.
- WAIT_RESP:
  - mem_req_o=0.
  - On mem_rvalid_i: owner's x_rvalid_o=1 and x_rdata_o=mem_rdata_i in the same cycle (combinational pass-through, zero added latency); state <= IDLE.
  - The non-owner's rvalid_o=0 and rdata_o=0.
  - Stays in WAIT_RESP indefinitely until rvalid.
- Requesters must hold req/addr/we/wdata stable until gnt. Dropping req before gnt is allowed; the arbiter then reselects that cycle.
- mem_rvalid_i in IDLE is ignored (no rvalid to either port).
- Throughput: max one transaction per 2 cycles (grant cycle, response cycle); back-to-back issue in the rvalid cycle is not supported.
- Simultaneous core_req_i and ext_req_i with counter < MaxCoreBurst: core wins, ext waits, no gnt to ext.
- Outputs during/after reset: all gnt/rvalid=0, rdata=0, mem_req_o follows the IDLE equation; it is 0 with no requests.

Test Plan:
1. Core only: core load addr 0x100, mem_gnt_i=1 same cycle, rvalid next cycle with rdata 0xDEADBEEF.
   -> core_gnt_o pulses 1 cycle; core_rvalid_o=1 with core_rdata_o=0xDEADBEEF; ext outputs stay 0.
2. Ext store: ext_we_i=4'b0011, ext_wdata_i=0x1234, addr 0x200.
   -> mem_we_o=0011, mem_wdata_o=0x1234, mem_addr_o=0x200; ext_gnt_o then ext_rvalid_o; core untouched.
3. Starvation: core and ext both request continuously, MaxCoreBurst=4, memory always grants with 1-cycle response.
   -> grant order core,core,core,core,ext,core,...; counter returns to 0 after the ext grant.
4. Memory stall: mem_gnt_i held 0 for 5 cycles with core_req_i=1.
   -> mem_req_o stays 1, no core_gnt_o until gnt; then mem_rvalid_i delayed 3 cycles -> no new mem_req_o while in WAIT_RESP.
5. Reset mid-operation: assert rst_ni low in WAIT_RESP, release, then drive a stray mem_rvalid_i.
   -> state IDLE, no rvalid to either port, counter 0; next core request is served normally.
6. Spurious rvalid: mem_rvalid_i=1 in IDLE with no requests.
   -> core_rvalid_o=ext_rvalid_o=0 and mem_req_o=0.
